// File: rtl/mips_tb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_tb_pkg
// Description : Shared definitions for the MIPS run controller.
//               - run_state_t : controller FSM state encoding
//               - c_fail_*    : fail_code values reported on a failed run
//               - clamp_count : limits a requested entry count to the table depth
// Revision    : 1.0 - initial release
// ============================================================================
package mips_tb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HOLD = 3'd1,
        ST_RUN  = 3'd2,
        ST_PASS = 3'd3,
        ST_FAIL = 3'd4
    } run_state_t;

    localparam logic [1:0] c_fail_none     = 2'd0;
    localparam logic [1:0] c_fail_mismatch = 2'd1;
    localparam logic [1:0] c_fail_timeout  = 2'd2;

    // A caller may ask for more entries than the table holds; the run then
    // checks the whole table and no more.
    function automatic int unsigned clamp_count(input int unsigned count,
                                                input int unsigned limit);
        return (count > limit) ? limit : count;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_exp_table.sv
`default_nettype none
// ============================================================================
// Module      : mips_exp_table
// Description : Expected-writeback table. One synchronous write port, one
//               asynchronous read port. Contents are not reset, so a table
//               loaded once survives controller resets and reruns.
// Ports       : clk                         - clock
//               i_we / i_widx               - write strobe and entry index
//               i_waddr / i_wdata           - register address / value stored
//               i_ridx                      - read index (match pointer)
//               o_raddr / o_rdata           - entry at i_ridx
// Revision    : 1.0 - initial release
// ============================================================================
module mips_exp_table #(
    parameter int DEPTH   = 16,
    parameter int RADDR_W = 5,
    parameter int DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_widx,
    input  logic [RADDR_W-1:0]         i_waddr,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_ridx,
    output logic [RADDR_W-1:0]         o_raddr,
    output logic [DATA_W-1:0]          o_rdata
);

    logic [RADDR_W+DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_widx] <= {i_waddr, i_wdata};
        end
    end

    assign {o_raddr, o_rdata} = r_mem[i_ridx];

endmodule
`default_nettype wire

// File: rtl/mips_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_run_ctrl
// Description : Run controller for a MIPS pipeline under test. Holds the core
//               in reset, releases it for a bounded run, and checks every
//               non-$0 register-file write against an ordered table of
//               expected (register, value) pairs. Reports pass / mismatch /
//               timeout with the table index at which the run stopped.
// Ports       : clk, reset (async, active low)
//               start                      - run request pulse
//               exp_we/exp_idx/exp_raddr/exp_rdata - table load (busy=0 only)
//               exp_count                  - entries to check (clamped to depth)
//               wb_valid/wb_addr/wb_data   - core register-file write port
//               core_reset                 - active-high reset to the core
//               busy, done, pass           - run status
//               fail_code                  - 0 none, 1 mismatch, 2 timeout
//               err_idx                    - table index at first failure
//               cycle_cnt                  - RUN cycles elapsed, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module mips_run_ctrl
    import mips_tb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int RADDR_W      = 5,
    parameter int EXP_DEPTH    = 16,
    parameter int HOLD_CYCLES  = 1,
    parameter int CYCLE_BUDGET = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         exp_we,
    input  logic [$clog2(EXP_DEPTH)-1:0] exp_idx,
    input  logic [RADDR_W-1:0]           exp_raddr,
    input  logic [DATA_W-1:0]            exp_rdata,
    input  logic [$clog2(EXP_DEPTH):0]   exp_count,
    input  logic                         wb_valid,
    input  logic [RADDR_W-1:0]           wb_addr,
    input  logic [DATA_W-1:0]            wb_data,
    output logic                         core_reset,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [1:0]                   fail_code,
    output logic [$clog2(EXP_DEPTH)-1:0] err_idx,
    output logic [15:0]                  cycle_cnt
);

    localparam int c_idx_w  = $clog2(EXP_DEPTH);
    localparam int c_cnt_w  = c_idx_w + 1;
    localparam int c_hold_w = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);

    run_state_t            r_state;
    logic [c_hold_w-1:0]   r_hold_cnt;
    logic [c_cnt_w-1:0]    r_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic [15:0]           r_cycle_cnt;
    logic                  r_core_reset;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic [1:0]            r_fail_code;
    logic [c_idx_w-1:0]    r_err_idx;

    logic [RADDR_W-1:0]    w_exp_addr;
    logic [DATA_W-1:0]     w_exp_data;
    logic [c_cnt_w-1:0]    w_count_clamped;
    logic                  w_wb_active;
    logic                  w_match;
    logic [c_cnt_w-1:0]    w_ptr_inc;
    logic                  w_last;
    logic [15:0]           w_cnt_inc;
    logic                  w_budget_hit;

    // The table is frozen while a run is in progress so the reference data
    // cannot move under the comparison.
    mips_exp_table #(
        .DEPTH   (EXP_DEPTH),
        .RADDR_W (RADDR_W),
        .DATA_W  (DATA_W)
    ) u_exp_table (
        .clk     (clk),
        .i_we    (exp_we && !r_busy),
        .i_widx  (exp_idx),
        .i_waddr (exp_raddr),
        .i_wdata (exp_rdata),
        .i_ridx  (r_ptr[c_idx_w-1:0]),
        .o_raddr (w_exp_addr),
        .o_rdata (w_exp_data)
    );

    assign w_count_clamped = c_cnt_w'(clamp_count(unsigned'(32'(exp_count)),
                                                  unsigned'(EXP_DEPTH)));

    // Writes to $0 are architectural no-ops and are not part of the trace.
    assign w_wb_active  = wb_valid && (wb_addr != '0);
    assign w_match      = (wb_addr == w_exp_addr) && (wb_data == w_exp_data);
    assign w_ptr_inc    = r_ptr + c_cnt_w'(1);
    assign w_last       = (w_ptr_inc == r_count);
    assign w_cnt_inc    = (r_cycle_cnt == 16'hFFFF) ? r_cycle_cnt
                                                    : r_cycle_cnt + 16'd1;
    assign w_budget_hit = ({16'd0, w_cnt_inc} >= unsigned'(32'(CYCLE_BUDGET)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_hold_cnt   <= '0;
            r_ptr        <= '0;
            r_count      <= '0;
            r_cycle_cnt  <= '0;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_code  <= c_fail_none;
            r_err_idx    <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (start) begin
                        r_state      <= ST_HOLD;
                        r_hold_cnt   <= '0;
                        r_ptr        <= '0;
                        r_count      <= w_count_clamped;
                        r_cycle_cnt  <= '0;
                        r_core_reset <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_fail_code  <= c_fail_none;
                        r_err_idx    <= '0;
                    end
                end

                ST_HOLD: begin
                    if (r_hold_cnt == c_hold_last) begin
                        if (r_count == '0) begin
                            // Nothing to check: pass without releasing the core.
                            r_state <= ST_PASS;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state      <= ST_RUN;
                            r_core_reset <= 1'b0;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
                    end
                end

                ST_RUN: begin
                    r_cycle_cnt <= w_cnt_inc;
                    // The match test comes first so a final match on the
                    // budget cycle still counts as a pass.
                    if (w_wb_active && w_match) begin
                        r_ptr <= w_ptr_inc;
                        if (w_last) begin
                            r_state      <= ST_PASS;
                            r_core_reset <= 1'b1;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_pass       <= 1'b1;
                        end else if (w_budget_hit) begin
                            r_state      <= ST_FAIL;
                            r_core_reset <= 1'b1;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_fail_code  <= c_fail_timeout;
                            r_err_idx    <= w_ptr_inc[c_idx_w-1:0];
                        end
                    end else if (w_wb_active) begin
                        r_state      <= ST_FAIL;
                        r_core_reset <= 1'b1;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_fail_code  <= c_fail_mismatch;
                        r_err_idx    <= r_ptr[c_idx_w-1:0];
                    end else if (w_budget_hit) begin
                        r_state      <= ST_FAIL;
                        r_core_reset <= 1'b1;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_fail_code  <= c_fail_timeout;
                        r_err_idx    <= r_ptr[c_idx_w-1:0];
                    end
                end

                default: begin
                    r_state      <= ST_IDLE;
                    r_core_reset <= 1'b1;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign core_reset = r_core_reset;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign fail_code  = r_fail_code;
    assign err_idx    = r_err_idx;
    assign cycle_cnt  = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mips_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_run_ctrl
// Description : Scoreboard bench for mips_run_ctrl. Each run pushes its
//               expected completion status; a monitor pops and compares on
//               every rising edge of done. Direct checks cover reset values,
//               core_reset behaviour, status hold and asynchronous abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_run_ctrl;

    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int DEPTH  = 16;
    localparam int IW     = 4;
    localparam int HOLD   = 1;
    localparam int BUDGET = 20;

    logic          clk;
    logic          reset;
    logic          start;
    logic          exp_we;
    logic [IW-1:0] exp_idx;
    logic [AW-1:0] exp_raddr;
    logic [DW-1:0] exp_rdata;
    logic [IW:0]   exp_count;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          core_reset;
    logic          busy;
    logic          done;
    logic          pass;
    logic [1:0]    fail_code;
    logic [IW-1:0] err_idx;
    logic [15:0]   cycle_cnt;

    mips_run_ctrl #(
        .DATA_W       (DW),
        .RADDR_W      (AW),
        .EXP_DEPTH    (DEPTH),
        .HOLD_CYCLES  (HOLD),
        .CYCLE_BUDGET (BUDGET)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .exp_we     (exp_we),
        .exp_idx    (exp_idx),
        .exp_raddr  (exp_raddr),
        .exp_rdata  (exp_rdata),
        .exp_count  (exp_count),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_code  (fail_code),
        .err_idx    (err_idx),
        .cycle_cnt  (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          pass;
        logic [1:0]    code;
        logic [IW-1:0] eidx;
        logic [15:0]   cnt;
        logic [7:0]    id;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic p, input logic [1:0] c,
                            input logic [IW-1:0] e, input logic [15:0] n,
                            input logic [7:0] id);
        exp_t x;
        x.pass = p; x.code = c; x.eidx = e; x.cnt = n; x.id = id;
        sb_q.push_back(x);
    endtask

    // Monitor: one scoreboard entry per completed run.
    initial begin : monitor
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && done && !prev_done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("run%0d_pass", e.id), 32'(pass), 32'(e.pass));
                    check($sformatf("run%0d_fail_code", e.id), 32'(fail_code), 32'(e.code));
                    check($sformatf("run%0d_err_idx", e.id), 32'(err_idx), 32'(e.eidx));
                    check($sformatf("run%0d_cycle_cnt", e.id), 32'(cycle_cnt), 32'(e.cnt));
                end
            end
            prev_done = done;
        end
    end

    // All tasks below are entered and left on a falling edge.
    task automatic load(input int idx, input int a, input int d);
        exp_we    = 1'b1;
        exp_idx   = IW'(idx);
        exp_raddr = AW'(a);
        exp_rdata = DW'(d);
        @(negedge clk);
        exp_we    = 1'b0;
    endtask

    task automatic wb(input int a, input int d);
        wb_valid = 1'b1;
        wb_addr  = AW'(a);
        wb_data  = DW'(d);
        @(negedge clk);
        wb_valid = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_start();
        int n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(busy && !core_reset) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("run_entry", 32'(busy && !core_reset), 32'd1);
    endtask

    task automatic wait_done(input string name, input int bound);
        int n;
        n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, 32'(done), 32'd1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        reset     = 1'b0;
        start     = 1'b0;
        exp_we    = 1'b0;
        exp_idx   = '0;
        exp_raddr = '0;
        exp_rdata = '0;
        exp_count = '0;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        @(negedge clk);
        idle(2);

        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_pass",       32'(pass),       32'd0);
        check("rst_fail_code",  32'(fail_code),  32'd0);
        check("rst_err_idx",    32'(err_idx),    32'd0);
        check("rst_cycle_cnt",  32'(cycle_cnt),  32'd0);

        // Load while reset is held: the table is not reset.
        load(0, 1, 5);
        load(1, 2, 7);
        load(2, 3, 12);
        exp_count = 5'd3;

        // Run 1: clean pass; start accepted on the first edge after release.
        reset = 1'b1;
        push_exp(1'b1, 2'd0, 4'd0, 16'd3, 8'd1);
        run_start();
        wb(1, 5); wb(2, 7); wb(3, 12);
        wait_done("run1", 10);
        check("run1_core_reset", 32'(core_reset), 32'd1);
        check("run1_busy",       32'(busy),       32'd0);
        // Writes outside RUN leave the status untouched.
        wb(1, 0);
        idle(1);
        check("hold_pass", 32'(pass),      32'd1);
        check("hold_done", 32'(done),      32'd1);
        check("hold_code", 32'(fail_code), 32'd0);

        // Run 2: second write mismatches.
        push_exp(1'b0, 2'd1, 4'd1, 16'd2, 8'd2);
        run_start();
        wb(1, 5); wb(2, 8);
        check("run2_core_reset", 32'(core_reset), 32'd1);
        wait_done("run2", 10);

        // Run 3: one match, then timeout on the budget cycle.
        push_exp(1'b0, 2'd2, 4'd1, 16'd20, 8'd3);
        run_start();
        wb(1, 5);
        wait_done("run3", 40);

        // Run 4: $0 writes interleaved are ignored.
        push_exp(1'b1, 2'd0, 4'd0, 16'd5, 8'd4);
        run_start();
        wb(1, 5); wb(0, 99); wb(2, 7); wb(0, 99); wb(3, 12);
        wait_done("run4", 10);

        // Run 5: zero entries -> pass straight from HOLD, core never released.
        exp_count = 5'd0;
        push_exp(1'b1, 2'd0, 4'd0, 16'd0, 8'd5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("run5_hold_busy",       32'(busy),       32'd1);
        check("run5_hold_core_reset", 32'(core_reset), 32'd1);
        @(negedge clk);
        check("run5_done",       32'(done),       32'd1);
        check("run5_core_reset", 32'(core_reset), 32'd1);
        exp_count = 5'd3;

        // Run 6: asynchronous abort after one match, then a full rerun.
        run_start();
        wb(1, 5);
        #2 reset = 1'b0;
        #1;
        check("abort_busy",       32'(busy),       32'd0);
        check("abort_done",       32'(done),       32'd0);
        check("abort_pass",       32'(pass),       32'd0);
        check("abort_core_reset", 32'(core_reset), 32'd1);
        check("abort_cycle_cnt",  32'(cycle_cnt),  32'd0);
        @(negedge clk);
        reset = 1'b1;
        push_exp(1'b1, 2'd0, 4'd0, 16'd3, 8'd6);
        run_start();
        wb(1, 5); wb(2, 7); wb(3, 12);
        wait_done("run6", 10);

        // Run 7: final match lands on the budget cycle -> pass.
        push_exp(1'b1, 2'd0, 4'd0, 16'd20, 8'd7);
        run_start();
        wb(1, 5); wb(2, 7);
        idle(17);
        wb(3, 12);
        wait_done("run7", 10);

        // Run 8: table write while busy is dropped; a rerun confirms it.
        push_exp(1'b1, 2'd0, 4'd0, 16'd4, 8'd8);
        run_start();
        exp_we = 1'b1; exp_idx = 4'd2; exp_raddr = 5'd3; exp_rdata = 32'd99;
        idle(1);
        exp_we = 1'b0;
        wb(1, 5); wb(2, 7); wb(3, 12);
        wait_done("run8", 10);
        push_exp(1'b1, 2'd0, 4'd0, 16'd3, 8'd9);
        run_start();
        wb(1, 5); wb(2, 7); wb(3, 12);
        wait_done("run9", 10);

        // Run 10: exp_count above depth clamps to the full 16-entry table.
        for (int i = 0; i < DEPTH; i++) load(i, i + 1, i * 3 + 1);
        exp_count = 5'd31;
        push_exp(1'b1, 2'd0, 4'd0, 16'd16, 8'd10);
        run_start();
        for (int i = 0; i < DEPTH; i++) wb(i + 1, i * 3 + 1);
        wait_done("run10", 10);

        idle(3);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_run_ctrl.md
MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, writeback data width.
REQ-002 SHALL have parameter RADDR_W, default 5, register-address width.
REQ-003 SHALL have parameter EXP_DEPTH, default 16, expected-writeback table entries (power of 2, ≥2).
REQ-004 SHALL have parameter HOLD_CYCLES, default 1, core reset hold length (≥1).
REQ-005 SHALL have parameter CYCLE_BUDGET, default 20, max RUN cycles before timeout (≥1).
REQ-006 SHALL have port clk input 1, single clock, all state on rising edge.
REQ-007 SHALL have port reset input 1, asynchronous active-low reset (0 = reset).
REQ-008 SHALL have port start input 1, run request pulse.
REQ-009 SHALL have port exp_we input 1, expected-table write strobe.
REQ-010 SHALL have port exp_idx input $clog2(EXP_DEPTH), table write index.
REQ-011 SHALL have port exp_raddr input RADDR_W, expected destination register.
REQ-012 SHALL have port exp_rdata input DATA_W, expected writeback value.
REQ-013 SHALL have port exp_count input $clog2(EXP_DEPTH)+1, number of valid entries (values > EXP_DEPTH clamp to EXP_DEPTH).
REQ-014 SHALL have port wb_valid input 1, core register-file write enable.
REQ-015 SHALL have port wb_addr input RADDR_W, core write register.
REQ-016 SHALL have port wb_data input DATA_W, core write data.
REQ-017 SHALL have port core_reset output 1, active-high reset driven to the MIPS pipeline top.
REQ-018 SHALL have ports busy, done, pass output 1 each, run status.
REQ-019 SHALL have port fail_code output 2, 0 none, 1 mismatch, 2 timeout.
REQ-020 SHALL have port err_idx output $clog2(EXP_DEPTH), table index at first failure.
REQ-021 SHALL have port cycle_cnt output 16, RUN cycles elapsed, saturating.

Function
REQ-022 FSM SHALL have states IDLE, HOLD, RUN, PASS, FAIL.
REQ-023 IDLE/PASS/FAIL: start=1 SHALL go to HOLD next cycle, clearing match pointer, cycle_cnt, fail_code, err_idx, pass, done.
REQ-024 HOLD SHALL assert core_reset for exactly HOLD_CYCLES cycles, then enter RUN.
REQ-025 core_reset SHALL be 1 in IDLE, HOLD, PASS, FAIL and 0 only in RUN.
REQ-026 In RUN, cycle_cnt SHALL increment by 1 per cycle, saturating at 16'hFFFF.
REQ-027 In RUN, a wb_valid cycle with wb_addr≠0 SHALL be compared to entry[ptr] (addr and data both).
REQ-028 Match SHALL increment ptr; when ptr reaches exp_count, next state PASS.
REQ-029 Mismatch SHALL go to FAIL with fail_code=1, err_idx=ptr.
REQ-030 Writes with wb_addr=0 SHALL be ignored (neither match nor mismatch).
REQ-031 cycle_cnt reaching CYCLE_BUDGET without completion SHALL go to FAIL with fail_code=2, err_idx=ptr.
REQ-032 Final match and budget expiry in the same cycle: match SHALL win (PASS).
REQ-033 exp_count=0 SHALL go HOLD→PASS directly without entering RUN.
REQ-034 PASS: done=1, pass=1; FAIL: done=1, pass=0; busy=1 exactly in HOLD and RUN.
REQ-035 start during HOLD/RUN SHALL be ignored.
REQ-036 exp_we SHALL write entry[exp_idx] only when busy=0; ignored when busy=1.
REQ-037 wb_valid outside RUN SHALL be ignored; status SHALL be held in PASS/FAIL until next start.
REQ-038 Outputs SHALL be registered (no combinational path from wb_* to status).

Reset
REQ-039 reset=0 SHALL asynchronously force IDLE, core_reset=1, busy=0, done=0, pass=0, fail_code=0, err_idx=0, cycle_cnt=0, ptr=0.
REQ-040 Table contents SHALL NOT be reset; reset mid-RUN SHALL abort with no PASS/FAIL indication.
REQ-041 Deassertion SHALL take effect at the next rising clk; first start is accepted on the first edge after release.

Structure
REQ-042 FSM state encoding and fail_code constants SHALL live in shared package mips_tb_pkg.
REQ-043 Expected table SHALL be sub-module mips_exp_table (write port, async read by ptr), no reset.

Verification
REQ-044 Load {($1,5),($2,7),($3,12)}, exp_count=3, start; core writes same three in order -> PASS, pass=1, fail_code=0.
REQ-045 Same table, second write ($2,8) -> FAIL, fail_code=1, err_idx=1, core_reset=1 next cycle.
REQ-046 CYCLE_BUDGET=20, only one matching write -> FAIL at cycle_cnt=20, fail_code=2, err_idx=1.
REQ-047 Interleave ($0,99) writes between expected ones -> still PASS; exp_count=0 -> PASS after HOLD_CYCLES, no RUN.
REQ-048 reset=0 mid-RUN after 1 match -> IDLE immediately, done=0; restart runs full check from entry 0.
REQ-049 Last match on budget cycle -> PASS; exp_we while busy -> table unchanged, verified on rerun.
